// File: rtl/alu_8bit.sv
// alu_8bit -- registered 8-bit arithmetic/logic unit for the Never8 datapath.
//
// Operand A is 5 bits, unsigned, and zero-extended to 8 bits. Operand B is
// 8 bits, unsigned. A 3-bit opcode selects the operation. The result and
// its flags are captured in output registers, so they appear one cycle
// after the operands are applied. There is no enable and no handshake: a
// new operation is accepted on every clock edge.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   opcode   in   3  000 ADD, 001 SUB, 010 AND, 011 OR,
//                    100 XOR, 101 NOT, 110 SHL, 111 SHR
//   a        in   5  operand A (unsigned)
//   b        in   8  operand B (unsigned)
//   zflag    out  1  registered zero flag (8-bit result == 0)
//   c        out  1  registered carry / borrow / shift-out flag
//   data_out out  8  registered result
module alu_8bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic [4:0] a,
  input  logic [7:0] b,
  output logic       zflag,
  output logic       c,
  output logic [7:0] data_out
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  logic [7:0] a8;
  logic [2:0] shamt;
  logic [8:0] add_w;
  logic [8:0] sub_w;
  logic [8:0] shl_w;
  logic [8:0] shr_w;
  logic [7:0] res_d;
  logic       cy_d;
  logic       z_d;

  logic [7:0] data_q;
  logic       c_q;
  logic       z_q;

  assign a8    = {3'b000, a};
  // Only the low three bits of A form the shift amount.
  assign shamt = a[2:0];

  // 9-bit add: bit 8 is the carry out of bit 7.
  assign add_w = {1'b0, a8} + {1'b0, b};
  // 9-bit subtract: bit 8 is set exactly when A8 < b (borrow).
  assign sub_w = {1'b0, a8} - {1'b0, b};

  // Left shift with a guard bit above the MSB: after shifting by s the guard
  // holds b[8-s], i.e. the last bit shifted out. For s == 0 it stays 0.
  assign shl_w = {1'b0, b} << shamt;
  // Right shift with a guard bit below the LSB: bits [8:1] are b >> s and
  // bit 0 holds b[s-1], the last bit shifted out. For s == 0 it stays 0.
  assign shr_w = {b, 1'b0} >> shamt;

  always_comb begin
    res_d = 8'h00;
    cy_d  = 1'b0;
    case (opcode)
      OP_ADD: begin
        res_d = add_w[7:0];
        cy_d  = add_w[8];
      end
      OP_SUB: begin
        res_d = sub_w[7:0];
        cy_d  = sub_w[8];
      end
      OP_AND: res_d = a8 & b;
      OP_OR:  res_d = a8 | b;
      OP_XOR: res_d = a8 ^ b;
      OP_NOT: res_d = ~b;
      OP_SHL: begin
        res_d = shl_w[7:0];
        cy_d  = shl_w[8];
      end
      OP_SHR: begin
        res_d = shr_w[8:1];
        cy_d  = shr_w[0];
      end
    endcase
  end

  // The zero flag looks only at the 8-bit result; the carry does not affect it.
  assign z_d = (res_d == 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= 8'h00;
      c_q    <= 1'b0;
      z_q    <= 1'b0;
    end else begin
      data_q <= res_d;
      c_q    <= cy_d;
      z_q    <= z_d;
    end
  end

  assign data_out = data_q;
  assign c        = c_q;
  assign zflag    = z_q;

endmodule

// File: tb/tb_alu_8bit.sv
`timescale 1ns/1ps
module tb_alu_8bit;

  logic       clk;
  logic       rst_n;
  logic [2:0] opcode;
  logic [4:0] a;
  logic [7:0] b;
  logic       zflag;
  logic       c;
  logic [7:0] data_out;

  int checks;
  int errors;

  alu_8bit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .a        (a),
    .b        (b),
    .zflag    (zflag),
    .c        (c),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the operands on the falling edge, then sample 1 ns after the next
  // rising edge.
  task automatic apply(input logic [2:0] op, input logic [4:0] av, input logic [7:0] bv);
    @(negedge clk);
    opcode = op;
    a      = av;
    b      = bv;
    @(posedge clk);
    #1;
    $display("op=%b a=%02h b=%02h -> data_out=%02h c=%b z=%b", op, av, bv, data_out, c, zflag);
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    opcode = 3'b000;
    a      = 5'd31;
    b      = 8'hFF;
    #2;
    checks++;
    if ({data_out, c, zflag} !== 10'b0) begin
      errors++;
      $display("FAIL reset_async actual d=%02h c=%b z=%b required d=00 c=0 z=0", data_out, c, zflag);
    end
    // Clock keeps running with inputs changing while reset is held.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      opcode = 3'(i + 5);
      a      = 5'(7 * i + 3);
      b      = 8'(8'h5A + i);
      @(posedge clk);
      #1;
      checks++;
      if ({data_out, c, zflag} !== 10'b0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d actual d=%02h c=%b z=%b required d=00 c=0 z=0", i, data_out, c, zflag);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(3'b000, 5'b00001, 8'h01);
    checks++;
    if ({data_out, c, zflag} !== {8'h02, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL first_capture actual d=%02h c=%b z=%b required d=02 c=0 z=0", data_out, c, zflag);
    end
  endtask

  task automatic test_add();
    apply(3'b000, 5'd31, 8'hFF);
    checks++;
    if ({data_out, c, zflag} !== {8'h1E, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_max actual d=%02h c=%b z=%b required d=1E c=1 z=0", data_out, c, zflag);
    end
    apply(3'b000, 5'd1, 8'hFF);
    checks++;
    if ({data_out, c, zflag} !== {8'h00, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL add_wrap_zero actual d=%02h c=%b z=%b required d=00 c=1 z=1", data_out, c, zflag);
    end
  endtask

  task automatic test_sub();
    apply(3'b001, 5'd5, 8'd5);
    checks++;
    if ({data_out, c, zflag} !== {8'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sub_equal actual d=%02h c=%b z=%b required d=00 c=0 z=1", data_out, c, zflag);
    end
    apply(3'b001, 5'd1, 8'd2);
    checks++;
    if ({data_out, c, zflag} !== {8'hFF, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sub_borrow actual d=%02h c=%b z=%b required d=FF c=1 z=0", data_out, c, zflag);
    end
    // A is zero-extended, so 31 - 32 borrows rather than treating A as signed.
    apply(3'b001, 5'd31, 8'd32);
    checks++;
    if ({data_out, c, zflag} !== {8'hFF, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sub_31_32 actual d=%02h c=%b z=%b required d=FF c=1 z=0", data_out, c, zflag);
    end
  endtask

  task automatic test_logic();
    logic [2:0] ops [4]  = '{3'b010, 3'b011, 3'b100, 3'b101};
    logic [7:0] exps [4] = '{8'h10, 8'hF5, 8'hE5, 8'h0F};
    for (int i = 0; i < 4; i++) begin
      apply(ops[i], 5'b10101, 8'hF0);
      checks++;
      if ({data_out, c, zflag} !== {exps[i], 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL logic op=%b actual d=%02h c=%b z=%b required d=%02h c=0 z=0", ops[i], data_out, c, zflag, exps[i]);
      end
    end
    // Preload a carry, then check that AND producing zero clears c and sets z.
    apply(3'b000, 5'd1, 8'hFF);
    apply(3'b010, 5'b01010, 8'h35);
    checks++;
    if ({data_out, c, zflag} !== {8'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL and_zero actual d=%02h c=%b z=%b required d=00 c=0 z=1", data_out, c, zflag);
    end
  endtask

  task automatic test_shift();
    logic [2:0] ops [6] = '{3'b110, 3'b111, 3'b110, 3'b111, 3'b110, 3'b111};
    logic [4:0] avs [6] = '{5'd1, 5'd1, 5'd0, 5'b11111, 5'd2, 5'b01011};
    logic [7:0] bvs [6] = '{8'h81, 8'h81, 8'h81, 8'h80, 8'hC0, 8'hFF};
    logic [7:0] eds [6] = '{8'h02, 8'h40, 8'h81, 8'h01, 8'h00, 8'h1F};
    logic       ecs [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       ezs [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      apply(ops[i], avs[i], bvs[i]);
      checks++;
      if ({data_out, c, zflag} !== {eds[i], ecs[i], ezs[i]}) begin
        errors++;
        $display("FAIL shift vec %0d actual d=%02h c=%b z=%b required d=%02h c=%b z=%b", i, data_out, c, zflag, eds[i], ecs[i], ezs[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops [7] = '{3'b000, 3'b001, 3'b100, 3'b110, 3'b111, 3'b011, 3'b101};
    logic [4:0] avs [7] = '{5'd10, 5'd3, 5'h1F, 5'd7, 5'd3, 5'd0, 5'd9};
    logic [7:0] bvs [7] = '{8'd20, 8'd4, 8'h1F, 8'h01, 8'hFF, 8'h00, 8'hFF};
    logic [7:0] eds [7] = '{8'h1E, 8'hFF, 8'h00, 8'h80, 8'h1F, 8'h00, 8'h00};
    logic       ecs [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       ezs [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [9:0] prev;
    prev = {data_out, c, zflag};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      opcode = ops[i];
      a      = avs[i];
      b      = bvs[i];
      #1;
      // New operands must not reach the outputs before the clock edge.
      checks++;
      if ({data_out, c, zflag} !== prev) begin
        errors++;
        $display("FAIL b2b_early vec %0d actual %03h required %03h", i, {data_out, c, zflag}, prev);
      end
      @(posedge clk);
      #1;
      $display("op=%b a=%02h b=%02h -> data_out=%02h c=%b z=%b", ops[i], avs[i], bvs[i], data_out, c, zflag);
      checks++;
      if ({data_out, c, zflag} !== {eds[i], ecs[i], ezs[i]}) begin
        errors++;
        $display("FAIL b2b vec %0d actual d=%02h c=%b z=%b required d=%02h c=%b z=%b", i, data_out, c, zflag, eds[i], ecs[i], ezs[i]);
      end
      prev = {eds[i], ecs[i], ezs[i]};
    end
  endtask

  task automatic test_async_reset();
    apply(3'b000, 5'd31, 8'hFF);
    checks++;
    if ({data_out, c, zflag} !== {8'h1E, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL async_preload actual d=%02h c=%b z=%b required d=1E c=1 z=0", data_out, c, zflag);
    end
    // Pulse reset well between edges (clk is high here, no edge is due).
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({data_out, c, zflag} !== 10'b0) begin
      errors++;
      $display("FAIL async_clear actual d=%02h c=%b z=%b required d=00 c=0 z=0", data_out, c, zflag);
    end
    // Hold reset across a rising edge with live operands: nothing is captured.
    @(negedge clk);
    opcode = 3'b101;
    b      = 8'h00;
    @(posedge clk);
    #1;
    checks++;
    if ({data_out, c, zflag} !== 10'b0) begin
      errors++;
      $display("FAIL async_hold actual d=%02h c=%b z=%b required d=00 c=0 z=0", data_out, c, zflag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(3'b101, 5'd0, 8'h00);
    checks++;
    if ({data_out, c, zflag} !== {8'hFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_resume actual d=%02h c=%b z=%b required d=FF c=0 z=0", data_out, c, zflag);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_shift();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual running required finished");
    $fatal(1, "timeout");
  end

endmodule
